wb_sram_bridge: RTL and testbench

Wishbone classic responder that lets the Caravel management core access one sky130_sram_2kbyte_1rw1r_32x512_8 macro through its port 0. It sits between the user-area Wishbone slave bus (wbs_*) and the SRAM port-0 pins. It is used for program loading and debug readback of IRAM/DRAM while the rvj1 core is held off the port by en_i.
It converts single Wishbone cycles into registered SRAM accesses, absorbs the SRAM read latency, and generates ack.

---
 rtl/wb_sram_bridge_pkg.sv | 23 ++
 rtl/wb_sram_bridge_if.sv | 25 ++
 rtl/wb_sram_bridge.sv | 121 ++++++++++++
 tb/tb_wb_sram_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared constants for the Wishbone-to-SRAM bridge: FSM encoding, window
// defaults for the IRAM/DRAM macros and the SRAM data width.
package wb_sram_pkg;

  localparam int unsigned SRAM_DW   = 32;

  localparam logic [31:0] IRAM_BASE = 32'h3000_0000;
  localparam logic [31:0] DRAM_BASE = 32'h3000_0800;
  localparam logic [31:0] WIN_MASK  = 32'hFFFF_F800;

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  ISSUE     = 2'd1;
  localparam logic [1:0]  RDWAIT    = 2'd2;
  localparam logic [1:0]  ACK       = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StIssue  = ISSUE,
    StRdWait = RDWAIT,
    StAck    = ACK
  } state_e;

endpackage

// File: rtl/wb_sram_bridge_if.sv
// Wishbone classic slave-side bus bundle between the management core and the
// SRAM bridge.
interface wb_sram_bridge_if;
  import wb_sram_pkg::*;

  logic               wbs_stb_i;
  logic               wbs_cyc_i;
  logic               wbs_we_i;
  logic [3:0]         wbs_sel_i;
  logic [SRAM_DW-1:0] wbs_dat_i;
  logic [31:0]        wbs_adr_i;
  logic               wbs_ack_o;
  logic [SRAM_DW-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone classic responder driving port 0 of a 32x512 SRAM macro: one
// registered SRAM access per bus cycle, read latency absorbed, single-cycle ack.
module wb_sram_bridge
  import wb_sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter logic [31:0] BASE_ADDR = IRAM_BASE,
  parameter logic [31:0] ADDR_MASK = WIN_MASK
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  wb_sram_bridge_if.slave    wbs,
  output logic               sram_clk0,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [3:0]         sram_wmask0,
  output logic [ADDR_W-1:0]  sram_addr0,
  output logic [SRAM_DW-1:0] sram_din0,
  input  logic [SRAM_DW-1:0] sram_dout0
);

  state_e             r_state, w_state_d;
  logic               r_csb, w_csb_d;
  logic               r_web, w_web_d;
  logic [3:0]         r_wmask, w_wmask_d;
  logic [ADDR_W-1:0]  r_addr, w_addr_d;
  logic [SRAM_DW-1:0] r_din, w_din_d;
  logic [SRAM_DW-1:0] r_dat, w_dat_d;

  logic w_req;
  logic w_hit;

  assign w_req = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_hit = (wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR;

  always_comb begin
    w_state_d = r_state;
    w_csb_d   = r_csb;
    w_web_d   = r_web;
    w_wmask_d = r_wmask;
    w_addr_d  = r_addr;
    w_din_d   = r_din;
    w_dat_d   = '0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_hit && en_i) begin
            w_state_d = StIssue;
            w_csb_d   = 1'b0;
            w_web_d   = ~wbs.wbs_we_i;
            w_wmask_d = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
            w_addr_d  = wbs.wbs_adr_i[ADDR_W+1:2];
            w_din_d   = wbs.wbs_dat_i;
          end else begin
            // Miss or bridge disabled: answer with zero data, SRAM untouched.
            w_state_d = StAck;
          end
        end
      end
      StIssue: begin
        // The SRAM captures on this edge even if the master has given up.
        w_csb_d   = 1'b1;
        w_web_d   = 1'b1;
        w_wmask_d = 4'h0;
        if (!wbs.wbs_cyc_i) begin
          w_state_d = StIdle;
        end else if (!r_web) begin
          w_state_d = StAck;
        end else begin
          w_state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (!wbs.wbs_cyc_i) begin
          w_state_d = StIdle;
        end else begin
          w_dat_d   = sram_dout0;
          w_state_d = StAck;
        end
      end
      StAck: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'h0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_d;
      r_csb   <= w_csb_d;
      r_web   <= w_web_d;
      r_wmask <= w_wmask_d;
      r_addr  <= w_addr_d;
      r_din   <= w_din_d;
      r_dat   <= w_dat_d;
    end
  end

  assign wbs.wbs_ack_o = (r_state == StAck) & wbs.wbs_cyc_i;
  assign wbs.wbs_dat_o = r_dat;

  assign sram_clk0   = clk_i;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Randomised self-checking bench for wb_sram_bridge: SRAM macro model plus a
// transaction-level reference (memory image, latency and issue-cycle rules).
module tb_wb_sram_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_F800;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        sram_clk0;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  wb_sram_bridge_if wbs ();

  wb_sram_bridge #(
    .ADDR_W    (9),
    .BASE_ADDR (BASE),
    .ADDR_MASK (MASK)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .en_i        (en),
    .wbs         (wbs),
    .sram_clk0   (sram_clk0),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // SRAM macro model: capture on the rising edge, read data one clock later.
  logic [31:0] sram_mem [512];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
        end
      end else begin
        sram_dout0 <= sram_mem[sram_addr0];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [512];
  int          exp_issue_cyc = -1;
  int          exp_ack_cyc   = -1;
  logic [31:0] exp_dat;
  logic        exp_web;
  logic [3:0]  exp_wmask;
  logic [8:0]  exp_addr;
  logic [31:0] exp_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Per-cycle comparison of every DUT output against the reference model.
  always @(negedge clk) begin
    logic e_ack;
    logic e_iss;
    e_ack = (cyc_cnt == exp_ack_cyc);
    e_iss = (cyc_cnt == exp_issue_cyc);
    chk("ack", {31'd0, wbs.wbs_ack_o}, {31'd0, e_ack});
    chk("dat_o", wbs.wbs_dat_o, e_ack ? exp_dat : 32'd0);
    chk("csb", {31'd0, sram_csb0}, {31'd0, ~e_iss});
    chk("web", {31'd0, sram_web0}, {31'd0, e_iss ? exp_web : 1'b1});
    chk("wmask", {28'd0, sram_wmask0}, {28'd0, e_iss ? exp_wmask : 4'h0});
    chk("sram_clk", {31'd0, sram_clk0}, 32'd0);
    if (e_iss) begin
      chk("addr", {23'd0, sram_addr0}, {23'd0, exp_addr});
      chk("din", sram_din0, exp_din);
    end
  end

  // One Wishbone cycle, started right after a rising edge (cycle N). t_abort>0
  // drops cyc after that many edges; the reference model is updated up front.
  task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                     input logic [3:0] t_sel, input int t_abort, output int lat,
                     output logic [31:0] rdat, output logic csb_seen,
                     output logic [3:0] iss_wmask);
    int          n;
    int          w;
    int          elat;
    logic        hit;
    n    = cyc_cnt;
    w    = int'(t_adr[10:2]);
    hit  = ((t_adr & MASK) == BASE) && en;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = t_we;
    wbs.wbs_adr_i = t_adr;
    wbs.wbs_dat_i = t_dat;
    wbs.wbs_sel_i = t_sel;
    if (hit) begin
      exp_issue_cyc = n + 1;
      exp_web       = ~t_we;
      exp_wmask     = t_we ? t_sel : 4'h0;
      exp_addr      = t_adr[10:2];
      exp_din       = t_dat;
      if (t_we) ref_mem[w] = merge(ref_mem[w], t_dat, t_sel);
      exp_dat = t_we ? 32'd0 : ref_mem[w];
      elat    = t_we ? 2 : 3;
    end else begin
      exp_dat = 32'd0;
      elat    = 1;
    end
    exp_ack_cyc = (t_abort > 0) ? -1 : n + elat;
    lat       = -1;
    rdat      = 32'd0;
    csb_seen  = 1'b0;
    iss_wmask = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!sram_csb0) csb_seen = 1'b1;
      if (k == 1) iss_wmask = sram_wmask0;
      if (wbs.wbs_ack_o && lat < 0) begin
        lat  = k;
        rdat = wbs.wbs_dat_o;
      end
      @(posedge clk);
      #1;
      if (lat >= 0 || k + 1 == t_abort) begin
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
      end
      if (lat >= 0) break;
    end
    if (t_abort <= 0 && lat < 0) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rdat;
    logic        cs;
    logic [3:0]  wm;
    logic [31:0] adr;
    int          kind;

    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = 32'd0;
      ref_mem[i]  = 32'd0;
    end
    rstn = 1'b0;
    en   = 1'b1;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_dat_i = 32'd0;
    wbs.wbs_adr_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
    chk("rst_dat", wbs.wbs_dat_o, 32'd0);
    chk("rst_csb", {31'd0, sram_csb0}, 32'd1);
    chk("rst_web", {31'd0, sram_web0}, 32'd1);
    chk("rst_wmask", {28'd0, sram_wmask0}, 32'd0);
    chk("rst_addr", {23'd0, sram_addr0}, 32'd0);
    chk("rst_din", sram_din0, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read-back.
    txn(1'b1, 32'h3000_0010, 32'hCAFE_BABE, 4'hF, 0, lat, rdat, cs, wm);
    chk("wr_lat", lat, 2);
    chk("mem4", sram_mem[4], 32'hCAFE_BABE);
    txn(1'b0, 32'h3000_0010, 32'd0, 4'hF, 0, lat, rdat, cs, wm);
    chk("rd_lat", lat, 3);
    chk("rd_dat", rdat, 32'hCAFE_BABE);

    // Byte-lane write.
    txn(1'b1, 32'h3000_0020, 32'h1122_3344, 4'hF, 0, lat, rdat, cs, wm);
    txn(1'b1, 32'h3000_0020, 32'h0000_00AA, 4'h1, 0, lat, rdat, cs, wm);
    chk("lane_wmask", {28'd0, wm}, 32'h1);
    txn(1'b0, 32'h3000_0020, 32'd0, 4'hF, 0, lat, rdat, cs, wm);
    chk("lane_dat", rdat, 32'h1122_33AA);

    // Outside the window.
    txn(1'b0, 32'h3000_0800, 32'd0, 4'hF, 0, lat, rdat, cs, wm);
    chk("miss_lat", lat, 1);
    chk("miss_dat", rdat, 32'd0);
    chk("miss_csb", {31'd0, cs}, 32'd0);

    // Disabled bridge drops the write.
    txn(1'b1, 32'h3000_0000, 32'h0102_0304, 4'hF, 0, lat, rdat, cs, wm);
    en = 1'b0;
    txn(1'b1, 32'h3000_0000, 32'h0000_0055, 4'hF, 0, lat, rdat, cs, wm);
    chk("dis_lat", lat, 1);
    chk("dis_csb", {31'd0, cs}, 32'd0);
    en = 1'b1;
    txn(1'b0, 32'h3000_0000, 32'd0, 4'hF, 0, lat, rdat, cs, wm);
    chk("dis_old", rdat, 32'h0102_0304);

    // Aborts: read dropped in RDWAIT, write dropped in ISSUE still commits.
    txn(1'b0, 32'h3000_0024, 32'd0, 4'hF, 2, lat, rdat, cs, wm);
    chk("abort_rd_ack", lat, -1);
    txn(1'b1, 32'h3000_0004, 32'h0BAD_F00D, 4'hF, 0, lat, rdat, cs, wm);
    chk("post_abort_lat", lat, 2);
    txn(1'b1, 32'h3000_0028, 32'hDEAD_BEEF, 4'hF, 1, lat, rdat, cs, wm);
    chk("abort_wr_ack", lat, -1);
    txn(1'b0, 32'h3000_0028, 32'd0, 4'hF, 0, lat, rdat, cs, wm);
    chk("abort_wr_commit", rdat, 32'hDEAD_BEEF);

    // Reset while the read is in ISSUE.
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_adr_i = 32'h3000_0008;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_csb", {31'd0, sram_csb0}, 32'd1);
    chk("rst_mid_ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, BASE + 32'(i * 4), 32'd0, 4'hF, 0, lat, rdat, cs, wm);
      chk("b2b_lat", lat, 3);
    end
    chk("b2b_w0", ref_mem[0], 32'h0102_0304);
    chk("b2b_w1", ref_mem[1], 32'h0BAD_F00D);

    // Randomised traffic.
    for (int t = 0; t < 250; t++) begin
      en   = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 9);
      if (kind < 7)      adr = BASE | {21'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      else if (kind < 9) adr = 32'h3000_0800 | {21'd0, 9'($urandom), 2'($urandom)};
      else               adr = $urandom;
      txn(1'($urandom), adr, $urandom, 4'($urandom), 0, lat, rdat, cs, wm);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
